// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : 8-bit combinational ALU with a registered {C,Z,N,V} status register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [2:0]       opcode,
  input  logic             flag_we,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic [3:0]       flags_q
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           sign_a;
  logic           sign_b;
  logic           sign_r;
  logic [3:0]     flags_d;

  // Extended-width add/sub: the top bit is the carry-out or the borrow.
  assign sum_ext  = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff_ext = {1'b0, operand_a} - {1'b0, operand_b};
  assign sign_a   = operand_a[WIDTH-1];
  assign sign_b   = operand_b[WIDTH-1];
  assign sign_r   = result[WIDTH-1];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        result = sum_ext[WIDTH-1:0];
        carry  = sum_ext[WIDTH];
      end
      OP_SUB: begin
        result = diff_ext[WIDTH-1:0];
        carry  = diff_ext[WIDTH];
      end
      OP_AND: result = operand_a & operand_b;
      OP_OR:  result = operand_a | operand_b;
      OP_XOR: result = operand_a ^ operand_b;
      OP_NOT: result = ~operand_a;
      OP_SHL: begin
        result = {operand_a[WIDTH-2:0], 1'b0};
        carry  = operand_a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, operand_a[WIDTH-1:1]};
        carry  = operand_a[0];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  always_comb begin
    overflow = 1'b0;
    if (opcode == OP_ADD) begin
      overflow = (sign_a == sign_b) && (sign_r != sign_a);
    end else if (opcode == OP_SUB) begin
      overflow = (sign_a != sign_b) && (sign_r != sign_a);
    end
  end

  assign zero     = ~|result;
  assign negative = sign_r;

  assign flags_d = flag_we ? {carry, zero, negative, overflow} : flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu : directed-vector, scoreboard-checked bench for alu
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [2:0]       opcode;
  logic             flag_we;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;
  logic [3:0]       flags_q;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
    logic             n;
    logic             v;
    logic [3:0]       flags;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  logic strobe;
  int   n_checked;

  alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .flag_we   (flag_we),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .negative  (negative),
    .overflow  (overflow),
    .flags_q   (flags_q)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input string fld, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, fld, act, req);
    end
  endtask

  // Monitor: every strobe toggle means the outputs are settled; pop and compare.
  initial begin
    exp_t e;
    n_checked = 0;
    forever begin
      @(strobe);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: output with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        chk(e.name, "result",   result,            e.res);
        chk(e.name, "zero",     {7'd0, zero},      {7'd0, e.z});
        chk(e.name, "carry",    {7'd0, carry},     {7'd0, e.c});
        chk(e.name, "negative", {7'd0, negative},  {7'd0, e.n});
        chk(e.name, "overflow", {7'd0, overflow},  {7'd0, e.v});
        chk(e.name, "flags_q",  {4'd0, flags_q},   {4'd0, e.flags});
      end
      n_checked++;
    end
  end

  task automatic push(input string name, input logic [7:0] res, input logic z, input logic c,
                      input logic n, input logic v, input logic [3:0] fl);
    exp_t e;
    e.name = name; e.res = res; e.z = z; e.c = c; e.n = n; e.v = v; e.flags = fl;
    exp_q.push_back(e);
  endtask

  // Inputs change on the falling edge; outputs are sampled 5 ns later, well before
  // the next rising edge, so flags_q reflects loads from earlier edges only.
  task automatic vec(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic we, input logic [7:0] res, input logic z, input logic c,
                     input logic n, input logic v, input logic [3:0] fl);
    @(negedge clk);
    opcode = op; operand_a = a; operand_b = b; flag_we = we;
    push(name, res, z, c, n, v, fl);
    #5 strobe = ~strobe;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    strobe  = 1'b0;
    rst_n   = 1'b1;
    opcode  = 3'b000; operand_a = 8'd3; operand_b = 8'd4; flag_we = 1'b0;

    // Reset with no clock edge yet: flags_q must clear asynchronously.
    #1 rst_n = 1'b0;
    push("reset_noclk", 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    #2 strobe = ~strobe;
    @(negedge clk);
    rst_n = 1'b1;

    //    name        op      A      B      we    res    z  c  n  v  flags_q
    vec("add_10_20", 3'b000, 8'd10, 8'd20, 1'b0, 8'd30, 0, 0, 0, 0, 4'b0000);
    vec("add_255_1", 3'b000, 8'hFF, 8'h01, 1'b1, 8'h00, 1, 1, 0, 0, 4'b0000);
    vec("and_12_10", 3'b010, 8'd12, 8'd10, 1'b0, 8'd8,  0, 0, 0, 0, 4'b1100);
    vec("or_12_10",  3'b011, 8'd12, 8'd10, 1'b0, 8'd14, 0, 0, 0, 0, 4'b1100);
    vec("sub_50_20", 3'b001, 8'd50, 8'd20, 1'b0, 8'd30, 0, 0, 0, 0, 4'b1100);
    vec("sub_10_10", 3'b001, 8'd10, 8'd10, 1'b0, 8'd0,  1, 0, 0, 0, 4'b1100);
    vec("sub_7f_ff", 3'b001, 8'h7F, 8'hFF, 1'b1, 8'h80, 0, 1, 1, 1, 4'b1100);
    vec("xor_ff_ff", 3'b100, 8'hFF, 8'hFF, 1'b0, 8'h00, 1, 0, 0, 0, 4'b1011);
    vec("not_0",     3'b101, 8'h00, 8'h5A, 1'b0, 8'hFF, 0, 0, 1, 0, 4'b1011);
    vec("shl_1",     3'b110, 8'h01, 8'hFF, 1'b0, 8'h02, 0, 0, 0, 0, 4'b1011);
    vec("shr_4",     3'b111, 8'h04, 8'hFF, 1'b0, 8'h02, 0, 0, 0, 0, 4'b1011);
    vec("shl_80",    3'b110, 8'h80, 8'h00, 1'b1, 8'h00, 1, 1, 0, 0, 4'b1011);
    vec("shr_1",     3'b111, 8'h01, 8'hAA, 1'b0, 8'h00, 1, 1, 0, 0, 4'b1100);
    vec("sub_80_01", 3'b001, 8'h80, 8'h01, 1'b1, 8'h7F, 0, 0, 0, 1, 4'b1100);
    vec("add_7f_01", 3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 0, 0, 1, 1, 4'b0001);
    vec("add_80_80", 3'b000, 8'h80, 8'h80, 1'b0, 8'h00, 1, 1, 0, 1, 4'b0001);

    // Reset mid-cycle: flags_q clears at once, combinational outputs keep going.
    @(negedge clk);
    opcode = 3'b000; operand_a = 8'd10; operand_b = 8'd20; flag_we = 1'b1;
    #2 rst_n = 1'b0;
    push("reset_mid", 8'd30, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    #2 strobe = ~strobe;
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release loads normally.
    vec("shr_81_we", 3'b111, 8'h81, 8'h00, 1'b1, 8'h40, 0, 1, 0, 0, 4'b0000);
    vec("or_0_0",    3'b011, 8'h00, 8'h00, 1'b0, 8'h00, 1, 0, 0, 0, 4'b1000);
    vec("and_f0_3c", 3'b010, 8'hF0, 8'h3C, 1'b0, 8'h30, 0, 0, 0, 0, 4'b1000);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    n_tests++;
    if (n_checked != 21) begin
      n_fail++;
      $display("FAIL checked_count: got %0d, expected 21", n_checked);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
